// File: rtl/write_pointer_full_if.sv
// Write-side FIFO pointer bundle: write request, synced read pointer, write address/pointer and flags.
// Latency: pure wiring, no storage.
// Backpressure: write_full refuses write_inc; refused writes only set write_overflow.
interface write_pointer_full_if #(
    parameter int address_size = 4
);
    logic                    write_inc;
    logic                    overflow_clear;
    logic [address_size:0]   read_pointer_s;
    logic                    write_en;
    logic [address_size-1:0] write_address;
    logic [address_size:0]   write_pointer;
    logic                    write_full;
    logic                    write_almost_full;
    logic [address_size:0]   write_count;
    logic                    write_overflow;

    // Producer side: issues writes and forwards the synchronized read pointer.
    modport master (
        output write_inc,
        output overflow_clear,
        output read_pointer_s,
        input  write_en,
        input  write_address,
        input  write_pointer,
        input  write_full,
        input  write_almost_full,
        input  write_count,
        input  write_overflow
    );

    // Pointer block side.
    modport slave (
        input  write_inc,
        input  overflow_clear,
        input  read_pointer_s,
        output write_en,
        output write_address,
        output write_pointer,
        output write_full,
        output write_almost_full,
        output write_count,
        output write_overflow
    );
endinterface

// File: rtl/write_pointer_full.sv
// Write-domain pointer/flag generator for a dual-clock FIFO (binary counter, Gray pointer, full/almost-full/count/overflow).
// Latency: write_en/write_address combinational in request cycle; pointer, count and flags one write_clk edge later.
// Backpressure: write_full blocks write_en; a refused write leaves pointer/count unchanged and sets sticky write_overflow.
module write_pointer_full #(
    parameter int address_size          = 4,
    parameter int almost_full_threshold = (1 << address_size) - 2
) (
    input  logic                write_clk,
    input  logic                wreset,
    write_pointer_full_if.slave bus
);
    localparam logic [address_size:0] LP_AF_THR = (address_size + 1)'(almost_full_threshold);

    logic [address_size:0] r_wbin;
    logic [address_size:0] r_wgray;
    logic [address_size:0] r_count;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_overflow;

    logic                  w_write_en;
    logic [address_size:0] w_wbin_next;
    logic [address_size:0] w_wgray_next;
    logic [address_size:0] w_full_match;
    logic [address_size:0] w_rbin;
    logic [address_size:0] w_count_next;
    logic                  w_full_next;
    logic                  w_almost_full_next;

    assign w_write_en   = bus.write_inc & ~r_full;
    assign w_wbin_next  = r_wbin + {{address_size{1'b0}}, w_write_en};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign w_full_match = {~bus.read_pointer_s[address_size:address_size-1],
                           bus.read_pointer_s[address_size-2:0]};
    assign w_full_next  = (w_wgray_next == w_full_match);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= address_size; i++) begin
            w_rbin[i] = ^(bus.read_pointer_s >> i);
        end
    end

    // Modulo subtraction always lands in 0..depth because the read pointer never passes the write pointer.
    assign w_count_next       = w_wbin_next - w_rbin;
    assign w_almost_full_next = (w_count_next >= LP_AF_THR);

    // Pointer and fill-level registers; read progress and the current write are folded into the same edge.
    always_ff @(posedge write_clk or posedge wreset) begin
        if (wreset) begin
            r_wbin        <= '0;
            r_wgray       <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wgray_next;
            r_count       <= w_count_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
        end
    end

    // Sticky overflow: a write attempt against a full FIFO wins over a same-cycle clear.
    always_ff @(posedge write_clk or posedge wreset) begin
        if (wreset) begin
            r_overflow <= 1'b0;
        end else if (bus.write_inc & r_full) begin
            r_overflow <= 1'b1;
        end else if (bus.overflow_clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.write_en          = w_write_en;
    assign bus.write_address     = r_wbin[address_size-1:0];
    assign bus.write_pointer     = r_wgray;
    assign bus.write_full        = r_full;
    assign bus.write_almost_full = r_almost_full;
    assign bus.write_count       = r_count;
    assign bus.write_overflow    = r_overflow;
endmodule

// File: tb/tb_write_pointer_full.sv
// Bench for write_pointer_full: integer reference model feeding a scoreboard queue, separate monitor compares.
// Latency: expectations for comb outputs checked mid-cycle, registered outputs checked just after the edge.
// Backpressure: model refuses writes while full and tracks sticky overflow.
module tb_write_pointer_full;
    localparam int A     = 4;
    localparam int DEPTH = 1 << A;
    localparam int THR   = DEPTH - 2;

    typedef struct {
        bit en;
        int addr;
        int ptr;
        bit full;
        bit af;
        int cnt;
        bit ovf;
    } item_t;

    logic write_clk = 1'b0;
    logic wreset    = 1'b1;

    write_pointer_full_if #(.address_size(A)) bus ();

    write_pointer_full #(
        .address_size          (A),
        .almost_full_threshold (THR)
    ) dut (
        .write_clk (write_clk),
        .wreset    (wreset),
        .bus       (bus)
    );

    always #5 write_clk = ~write_clk;

    item_t sb_q[$];
    int    n_chk    = 0;
    int    n_fail   = 0;
    bit    mon_busy = 1'b0;
    int    prev_ptr = 0;

    // Reference model: plain counts of accepted writes and of reads seen through the synchronizer.
    int m_w    = 0;
    int m_r    = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One write-clock cycle of stimulus; expected results pushed for the monitor.
    task automatic step(input bit inc, input bit clr, input int new_r);
        item_t it;
        int    fill;
        @(posedge write_clk);
        #2;
        bus.write_inc      = inc;
        bus.overflow_clear = clr;
        bus.read_pointer_s = (A + 1)'(gray(new_r % (2 * DEPTH)));
        it.en   = inc && !m_full;
        it.addr = m_w % DEPTH;
        it.ovf  = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        if (it.en) m_w++;
        fill    = m_w - new_r;
        it.cnt  = fill;
        it.full = (fill == DEPTH);
        it.af   = (fill >= THR);
        it.ptr  = gray(m_w % (2 * DEPTH));
        m_full  = it.full;
        m_ovf   = it.ovf;
        m_r     = new_r;
        sb_q.push_back(it);
    endtask

    // Park inputs idle and let the monitor consume everything queued.
    task automatic drain();
        int k;
        step(1'b0, 1'b0, m_r);
        k = 0;
        while ((sb_q.size() != 0 || mon_busy) && k < 20) begin
            @(posedge write_clk);
            #3;
            k++;
        end
        chk("drain_timeout", (sb_q.size() != 0 || mon_busy) ? 1 : 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_write_address"}, int'(bus.write_address), 0);
        chk({tag, "_write_pointer"}, int'(bus.write_pointer), 0);
        chk({tag, "_write_full"}, int'(bus.write_full), 0);
        chk({tag, "_write_almost_full"}, int'(bus.write_almost_full), 0);
        chk({tag, "_write_count"}, int'(bus.write_count), 0);
        chk({tag, "_write_overflow"}, int'(bus.write_overflow), 0);
    endtask

    task automatic model_reset();
        m_w      = 0;
        m_r      = 0;
        m_full   = 1'b0;
        m_ovf    = 1'b0;
        prev_ptr = 0;
    endtask

    // Monitor: comb outputs mid-cycle, registered outputs right after the edge.
    initial begin
        item_t it;
        forever begin
            @(negedge write_clk);
            if (sb_q.size() > 0) begin
                it       = sb_q.pop_front();
                mon_busy = 1'b1;
                chk("write_en", int'(bus.write_en), int'(it.en));
                chk("write_address", int'(bus.write_address), it.addr);
                @(posedge write_clk);
                #1;
                chk("write_pointer", int'(bus.write_pointer), it.ptr);
                chk("ptr_bit_changes", $countones(bus.write_pointer ^ (A + 1)'(prev_ptr)), it.en ? 1 : 0);
                chk("write_full", int'(bus.write_full), int'(it.full));
                chk("write_almost_full", int'(bus.write_almost_full), int'(it.af));
                chk("write_count", int'(bus.write_count), it.cnt);
                chk("write_overflow", int'(bus.write_overflow), int'(it.ovf));
                prev_ptr = int'(bus.write_pointer);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int rmax;
        bus.write_inc      = 1'b0;
        bus.overflow_clear = 1'b0;
        bus.read_pointer_s = '0;

        // Reset state; under reset write_en follows write_inc.
        repeat (3) @(posedge write_clk);
        #1;
        check_zero("reset");
        bus.write_inc = 1'b1;
        #1;
        chk("reset_write_en", int'(bus.write_en), 1);
        bus.write_inc = 1'b0;
        @(negedge write_clk);
        wreset = 1'b0;
        model_reset();

        // Fill to full with no reads: addresses 0..15, full/count 16/pointer 11000 after the 16th edge.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0);
        // Refused write while full sets overflow; set beats clear; clear alone clears.
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        // Reads advance without writes: full drops, almost-full falls at count 13.
        step(1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 2);
        step(1'b0, 1'b0, 3);
        drain();
        chk("directed_end_count", int'(bus.write_count), 13);

        // Wrap-around: count held at 2 while pointer rolls over 10000 -> 00000.
        step(1'b0, 1'b0, m_w - 2);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, m_w - 1);
        drain();
        chk("wrap_total_writes", m_w, 56);

        // Random traffic: a write-heavy half then a read-heavy half.
        for (int i = 0; i < 400; i++) begin
            rmax = (i < 200) ? 1 : 3;
            if (m_w - m_r < rmax) rmax = m_w - m_r;
            step(($urandom % 4) != 0, ($urandom % 8) == 0, m_r + int'($urandom_range(0, rmax)));
        end
        drain();

        // Reset mid-stream with a write pending: outputs clear at once, write lost.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, m_r);
        drain();
        @(negedge write_clk);
        bus.write_inc = 1'b1;
        #1;
        wreset = 1'b1;
        #1;
        check_zero("midreset");
        chk("midreset_write_en", int'(bus.write_en), 1);
        @(negedge write_clk);
        bus.write_inc      = 1'b0;
        bus.read_pointer_s = '0;
        wreset             = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
